// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader_pkg
// Brief   : Shared defaults and FSM state encoding for the instruction loader.
// Revision: 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_WORD_W = 32;
    localparam int MAX_WORDS  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module  : byte_assembler
// Brief   : Packs an MSB-first byte stream into words; flags the final byte.
// Revision: 1.0 - initial release
// ============================================================================
module byte_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_ready
);

    localparam int         c_BYTES = WORD_W / 8;
    localparam logic [1:0] c_LAST  = 2'(c_BYTES - 1);

    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_accept) begin
            r_word  <= {r_word[WORD_W-9:0], i_byte};
            r_count <= (r_count == c_LAST) ? 2'd0 : r_count + 2'd1;
        end
    end

    // Asserted in the same cycle the last byte is taken, so the write follows next edge.
    assign o_word_ready = i_accept && (r_count == c_LAST);
    assign o_word       = r_word;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Brief   : Streams bytes into instruction memory, holding the CPU until done.
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [WORD_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_wraddress,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W:0] c_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_index;
    logic [7:0]        r_checksum;
    logic [ADDR_W:0]   w_len_clamped;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_word_ready;
    logic              w_last_word;
    logic [WORD_W-1:0] w_word;

    assign w_len_clamped = (load_len > c_MAX_LEN) ? c_MAX_LEN : load_len;
    assign w_start_ok    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept      = rx_valid && rx_ready;
    assign w_last_word   = ({1'b0, r_index} == (r_len - c_ONE));

    byte_assembler #(
        .WORD_W (WORD_W)
    ) u_byte_assembler (
        .clk          (clock),
        .rst          (reset),
        .i_clear      (w_start_ok),
        .i_accept     (w_accept),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next_state = (w_len_clamped == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (w_word_ready) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                w_next_state = w_last_word ? DONE : LOAD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        mem_wren = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        case (r_state)
            LOAD: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            WRITE: begin
                mem_wren = 1'b1;
                cpu_hold = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_len      <= '0;
            r_index    <= '0;
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_len      <= w_len_clamped;
            r_index    <= '0;
            r_checksum <= '0;
        end else begin
            if (w_accept) begin
                r_checksum <= r_checksum ^ rx_data;
            end
            if (r_state == WRITE) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign mem_data      = w_word;
    assign mem_wraddress = r_index;
    assign checksum      = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_loader
// Brief   : Directed bench for imem_loader with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] load_len = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] mem_data;
    logic [9:0]  mem_wraddress;
    logic        mem_wren;
    logic        cpu_hold;
    logic        done;
    logic [7:0]  checksum;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] cap_data[$];
    int          cap_addr[$];

    // Model: load progress counted in bytes and words rather than FSM states.
    bit          m_live = 0;
    bit          m_active = 0;
    bit          m_done = 0;
    bit          m_wpend = 0;
    int          m_len = 0;
    int          m_bytes = 0;
    int          m_writes = 0;
    int          m_addr = 0;
    logic [31:0] m_word = '0;
    logic [7:0]  m_ck = '0;

    imem_loader #(
        .ADDR_W (10),
        .WORD_W (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .load_len      (load_len),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .mem_data      (mem_data),
        .mem_wraddress (mem_wraddress),
        .mem_wren      (mem_wren),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .checksum      (checksum)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Outputs are checked against the model, then the model advances on the
    // inputs that the coming rising edge will sample.
    initial begin
        forever begin
            @(negedge clock);
            if (m_live) begin
                chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_active && !m_wpend});
                chk("mem_wren", {31'd0, mem_wren}, {31'd0, m_wpend});
                chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_active});
                chk("done",     {31'd0, done},     {31'd0, m_done});
                chk("checksum", {24'd0, checksum}, {24'd0, m_ck});
                if (m_wpend) begin
                    chk("mem_data", mem_data, m_word);
                    chk("mem_wraddress", {22'd0, mem_wraddress}, m_addr);
                end
                if (mem_wren) begin
                    cap_data.push_back(mem_data);
                    cap_addr.push_back(int'(mem_wraddress));
                end
            end
            m_live = 1;
            if (reset) begin
                m_active = 0;
                m_done   = 0;
                m_wpend  = 0;
                m_ck     = '0;
            end else if (m_wpend) begin
                m_wpend = 0;
                m_writes++;
                if (m_writes == m_len) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end else if (m_active) begin
                if (rx_valid) begin
                    m_word = {m_word[23:0], rx_data};
                    m_ck   = m_ck ^ rx_data;
                    m_bytes++;
                    if (m_bytes % 4 == 0) begin
                        m_wpend = 1;
                        m_addr  = m_writes;
                    end
                end
            end else if (start) begin
                m_len    = (int'(load_len) > 1024) ? 1024 : int'(load_len);
                m_ck     = '0;
                m_bytes  = 0;
                m_writes = 0;
                m_done   = (m_len == 0);
                m_active = (m_len != 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        load_len = 11'(len);
        tick();
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 16; i++) begin
            acc = rx_ready;
            tick();
            if (acc) return;
        end
        chk("rx accept timeout", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 8; i++) begin
            if (done) break;
            tick();
        end
        chk("done reached", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("reset cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("reset done",     {31'd0, done},     32'd0);
        chk("reset mem_wren", {31'd0, mem_wren}, 32'd0);
        chk("reset checksum", {24'd0, checksum}, 32'd0);

        // Two words back to back; the XOR of the eight bytes is 0x04.
        cap_data.delete(); cap_addr.delete();
        do_start(2);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        rx_valid = 1'b0;
        wait_done();
        chk("t1 writes", cap_data.size(), 32'd2);
        if (cap_data.size() == 2) begin
            chk("t1 word0", cap_data[0], 32'h01020304);
            chk("t1 addr0", cap_addr[0], 32'd0);
            chk("t1 word1", cap_data[1], 32'hAABBCCDD);
            chk("t1 addr1", cap_addr[1], 32'd1);
        end
        chk("t1 checksum", {24'd0, checksum}, 32'h04);

        // Single word with a bubble after every byte.
        cap_data.delete(); cap_addr.delete();
        do_start(1);
        send_byte(8'hDE); rx_valid = 1'b0; tick();
        send_byte(8'hAD); rx_valid = 1'b0; tick();
        send_byte(8'hBE); rx_valid = 1'b0; tick();
        send_byte(8'hEF); rx_valid = 1'b0;
        wait_done();
        chk("t2 wren cycles", cap_data.size(), 32'd1);
        if (cap_data.size() == 1) chk("t2 word", cap_data[0], 32'hDEADBEEF);

        // Reset after two bytes, with start and rx_valid also high that cycle.
        cap_data.delete(); cap_addr.delete();
        do_start(4);
        send_byte(8'h55); send_byte(8'h66);
        rx_data = 8'h77; start = 1'b1; load_len = 11'd3; reset = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
        tick();
        chk("t3 wren count", cap_data.size(), 32'd0);
        chk("t3 cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("t3 done", {31'd0, done}, 32'd0);
        do_start(1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        rx_valid = 1'b0;
        wait_done();
        chk("t3 fresh writes", cap_data.size(), 32'd1);
        if (cap_data.size() == 1) chk("t3 fresh word", cap_data[0], 32'h11223344);

        // Start during LOAD must not restart the load or move the index.
        cap_data.delete(); cap_addr.delete();
        do_start(2);
        send_byte(8'h10); send_byte(8'h20);
        rx_valid = 1'b0;
        do_start(5);
        send_byte(8'h30); send_byte(8'h40);
        send_byte(8'h50); send_byte(8'h60); send_byte(8'h70); send_byte(8'h80);
        rx_valid = 1'b0;
        wait_done();
        chk("t4 writes", cap_data.size(), 32'd2);
        if (cap_data.size() == 2) begin
            chk("t4 word0", cap_data[0], 32'h10203040);
            chk("t4 addr1", cap_addr[1], 32'd1);
        end

        // Zero length from IDLE goes straight to DONE.
        do_reset();
        cap_data.delete(); cap_addr.delete();
        do_start(0);
        chk("t4 len0 done", {31'd0, done}, 32'd1);
        chk("t4 len0 hold", {31'd0, cpu_hold}, 32'd0);
        tick();
        chk("t4 len0 writes", cap_data.size(), 32'd0);

        // Full memory with rx_valid held high, including through WRITE cycles.
        cap_data.delete(); cap_addr.delete();
        do_start(1024);
        for (int k = 0; k < 4096; k++) send_byte(8'(k * 37 + 5));
        rx_valid = 1'b0;
        wait_done();
        chk("t5 writes", cap_data.size(), 32'd1024);
        if (cap_data.size() == 1024) chk("t5 last addr", cap_addr[1023], 32'd1023);

        // Oversized length clamps to the memory depth.
        cap_data.delete(); cap_addr.delete();
        do_start(2000);
        for (int k = 0; k < 4096; k++) send_byte(8'(k * 13 + 1));
        rx_valid = 1'b0;
        wait_done();
        tick(); tick();
        chk("t5 clamp writes", cap_data.size(), 32'd1024);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
